// File: rtl/lw_sha_msg_padder_if.sv
// rtl/lw_sha_msg_padder_if.sv - message-in / padded-word-out handshake bundle for the SHA padder
interface lw_sha_msg_padder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  in_last_i;
    logic [1:0]            in_bytes_i;
    logic                  empty_i;
    logic                  abort_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_block_end_o;
    logic                  out_last_o;

    // padder side
    modport slave (
        input  in_valid_i, in_data_i, in_last_i, in_bytes_i, empty_i, abort_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_block_end_o, out_last_o
    );

    // message source / hash core side
    modport master (
        output in_valid_i, in_data_i, in_last_i, in_bytes_i, empty_i, abort_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_block_end_o, out_last_o
    );
endinterface

// File: rtl/lw_sha_msg_padder.sv
// rtl/lw_sha_msg_padder.sv - SHA-1/SHA-256 message padder producing 512-bit blocks as 32-bit words
module lw_sha_msg_padder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 areset_i,
    lw_sha_msg_padder_if.slave   bus
);

    typedef enum logic [2:0] {
        S_DATA,
        S_PAD,
        S_ZERO,
        S_LEN_HI,
        S_LEN_LO
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_idx;
    logic [63:0]           r_len;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_block_end;
    logic                  r_out_last;

    logic                  w_can_load;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_load_last;
    logic [63:0]           w_len_next;
    logic                  w_clear_msg;
    logic [3:0]            w_idx_inc;
    state_t                w_pad_next;
    logic [DATA_WIDTH-1:0] w_masked;

    // Output register can take a new word when it is empty or being drained this cycle.
    assign w_can_load = !r_out_valid || bus.out_ready_i;
    assign w_idx_inc  = r_idx + 4'd1;
    // After the 0x80 word, jump straight to the length when the next slot is word 14.
    assign w_pad_next = (w_idx_inc == 4'd14) ? S_LEN_HI : S_ZERO;

    assign bus.in_ready_o      = (r_state == S_DATA) && w_can_load;
    assign bus.out_valid_o     = r_out_valid;
    assign bus.out_data_o      = r_out_data;
    assign bus.out_block_end_o = r_out_block_end;
    assign bus.out_last_o      = r_out_last;

    // Partial final word: keep valid leading bytes, append 0x80, zero the rest.
    always_comb begin
        w_masked = '0;
        case (bus.in_bytes_i)
            2'd1:    w_masked = {bus.in_data_i[31:24], 8'h80, 16'h0000};
            2'd2:    w_masked = {bus.in_data_i[31:16], 8'h80, 8'h00};
            2'd3:    w_masked = {bus.in_data_i[31:8], 8'h80};
            default: w_masked = bus.in_data_i;
        endcase
    end

    // Next-state, word to load and running bit length.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_data  = '0;
        w_load_last  = 1'b0;
        w_len_next   = r_len;
        w_clear_msg  = 1'b0;
        case (r_state)
            S_DATA: begin
                if (bus.in_valid_i) begin
                    if (w_can_load) begin
                        w_load = 1'b1;
                        if (!bus.in_last_i) begin
                            w_load_data = bus.in_data_i;
                            w_len_next  = r_len + 64'd32;
                        end else if (bus.in_bytes_i == 2'd0) begin
                            w_load_data  = bus.in_data_i;
                            w_len_next   = r_len + 64'd32;
                            w_state_next = S_PAD;
                        end else begin
                            w_load_data  = w_masked;
                            w_len_next   = r_len + {59'd0, bus.in_bytes_i, 3'b000};
                            w_state_next = w_pad_next;
                        end
                    end
                end else if (bus.empty_i && (r_idx == 4'd0) && (r_len == 64'd0)) begin
                    w_state_next = S_PAD;
                end
            end
            S_PAD: begin
                if (w_can_load) begin
                    w_load       = 1'b1;
                    w_load_data  = 32'h8000_0000;
                    w_state_next = w_pad_next;
                end
            end
            S_ZERO: begin
                if (w_can_load) begin
                    w_load = 1'b1;
                    if (w_idx_inc == 4'd14) begin
                        w_state_next = S_LEN_HI;
                    end
                end
            end
            S_LEN_HI: begin
                if (w_can_load) begin
                    w_load       = 1'b1;
                    w_load_data  = r_len[63:32];
                    w_state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_can_load) begin
                    w_load       = 1'b1;
                    w_load_data  = r_len[31:0];
                    w_load_last  = 1'b1;
                    w_clear_msg  = 1'b1;
                    w_state_next = S_DATA;
                end
            end
            default: begin
                w_state_next = S_DATA;
            end
        endcase
    end

    // State, word index and length; abort wins over everything except reset.
    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            r_state <= S_DATA;
            r_idx   <= 4'd0;
            r_len   <= 64'd0;
        end else if (bus.abort_i) begin
            r_state <= S_DATA;
            r_idx   <= 4'd0;
            r_len   <= 64'd0;
        end else begin
            r_state <= w_state_next;
            r_len   <= w_clear_msg ? 64'd0 : w_len_next;
            if (w_load) begin
                r_idx <= w_clear_msg ? 4'd0 : w_idx_inc;
            end
        end
    end

    // Output word register: holds under backpressure, reloads on empty or drain.
    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_block_end <= 1'b0;
            r_out_last      <= 1'b0;
        end else if (bus.abort_i) begin
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_block_end <= 1'b0;
            r_out_last      <= 1'b0;
        end else if (w_load) begin
            r_out_valid     <= 1'b1;
            r_out_data      <= w_load_data;
            r_out_block_end <= (r_idx == 4'd15);
            r_out_last      <= w_load_last;
        end else if (bus.out_ready_i) begin
            r_out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lw_sha_msg_padder.sv
// tb/tb_lw_sha_msg_padder.sv - scoreboard bench for the SHA message padder
module tb_lw_sha_msg_padder;

    typedef struct packed {
        logic [31:0] data;
        logic        be;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lw_sha_msg_padder_if #(.DATA_WIDTH(32)) bus ();

    lw_sha_msg_padder #(.DATA_WIDTH(32)) dut (
        .clk_i    (clk),
        .areset_i (rst),
        .bus      (bus)
    );

    exp_t        exp_q[$];
    logic [7:0]  msg_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          out_cnt = 0;
    int          rdy_mode = 0;
    bit          prev_stall = 0;
    exp_t        prev_word;

    // Reference padding: message bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic push_expected();
        logic [7:0]  pb[$];
        logic [63:0] bits;
        int          nw;
        exp_t        e;
        pb = {};
        foreach (msg_q[i]) pb.push_back(msg_q[i]);
        pb.push_back(8'h80);
        while ((pb.size() % 64) != 56) pb.push_back(8'h00);
        bits = 64'(msg_q.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) pb.push_back(bits[8*k +: 8]);
        nw = pb.size() / 4;
        for (int i = 0; i < nw; i++) begin
            e.data = {pb[4*i], pb[4*i+1], pb[4*i+2], pb[4*i+3]};
            e.be   = ((i % 16) == 15);
            e.last = (i == nw - 1);
            exp_q.push_back(e);
        end
        out_cnt = 0;
    endtask

    // One clock: observe outputs at negedge, then advance to just after the next posedge.
    task automatic tick(output bit acc);
        exp_t got;
        exp_t e;
        @(negedge clk);
        got = {bus.out_data_o, bus.out_block_end_o, bus.out_last_o};
        if (prev_stall) begin
            n_tests++;
            if (bus.out_valid_o !== 1'b1 || got !== prev_word) begin
                n_fail++;
                $display("FAIL hold: valid=%b word=%h, required valid=1 word=%h", bus.out_valid_o, got, prev_word);
            end
        end
        if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b0) begin
            n_tests++;
            if (bus.in_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL in_ready_stall: in_ready=%b, required 0", bus.in_ready_o);
            end
        end
        prev_stall = (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b0);
        prev_word  = got;
        if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got data=%h be=%b last=%b, required no word", got.data, got.be, got.last);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL word%0d: got data=%h be=%b last=%b, required data=%h be=%b last=%b",
                             out_cnt, got.data, got.be, got.last, e.data, e.be, e.last);
                end
            end
            out_cnt++;
        end
        acc = (bus.in_valid_i === 1'b1) && (bus.in_ready_o === 1'b1);
        @(posedge clk);
        #1;
        if (rdy_mode == 1) bus.out_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive_word(input int w);
        int nb;
        logic [31:0] d;
        nb = msg_q.size();
        for (int b = 0; b < 4; b++) d[31-8*b -: 8] = (4*w + b < nb) ? msg_q[4*w+b] : 8'hA5;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        bus.in_last_i  = (w == (nb + 3) / 4 - 1);
        bus.in_bytes_i = bus.in_last_i ? 2'(nb % 4) : 2'd0;
    endtask

    task automatic drain();
        bit acc;
        int cnt;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 400) begin
            tick(acc);
            cnt++;
        end
        n_tests++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        if (rdy_mode == 0) bus.out_ready_i = 1'b1;
        tick(acc);
        tick(acc);
    endtask

    // Sends msg_q as words; stall_at >= 2 drops out_ready for 3 cycles before that word.
    task automatic send_msg(input int stall_at);
        bit acc;
        int cnt;
        int nw;
        push_expected();
        nw = (msg_q.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            drive_word(w);
            cnt = 0;
            acc = 0;
            while (!acc && cnt < 200) begin
                if (w == stall_at && cnt < 3) bus.out_ready_i = 1'b0;
                else if (rdy_mode == 0) bus.out_ready_i = 1'b1;
                tick(acc);
                cnt++;
            end
            bus.empty_i = 1'b0;
            if (!acc) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: word %0d not accepted, required accept", w);
            end
        end
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        drain();
    endtask

    task automatic set_abc();
        msg_q = {8'h61, 8'h62, 8'h63};
    endtask

    task automatic set_random(input int n);
        msg_q = {};
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 32'h0 || bus.out_block_end_o !== 1'b0 ||
            bus.out_last_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: valid=%b data=%h be=%b last=%b in_ready=%b, required 0 0 0 0 1",
                     bus.out_valid_o, bus.out_data_o, bus.out_block_end_o, bus.out_last_o, bus.in_ready_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_abc();
        set_abc();
        send_msg(-1);
    endtask

    task automatic test_empty();
        bit acc;
        msg_q = {};
        push_expected();
        bus.empty_i = 1'b1;
        tick(acc);
        bus.empty_i = 1'b0;
        drain();
        // empty_i alongside a valid word must be ignored
        set_abc();
        bus.empty_i = 1'b1;
        send_msg(-1);
    endtask

    task automatic test_boundaries();
        int lens[5] = '{55, 56, 61, 63, 64};
        foreach (lens[i]) begin
            set_random(lens[i]);
            send_msg(-1);
        end
    endtask

    task automatic test_backpressure();
        set_random(40);
        send_msg(4);
    endtask

    task automatic test_abort();
        bit acc;
        int cnt;
        set_random(40);
        push_expected();
        for (int w = 0; w < 5; w++) begin
            drive_word(w);
            cnt = 0;
            acc = 0;
            while (!acc && cnt < 50) begin
                tick(acc);
                cnt++;
            end
        end
        bus.in_valid_i = 1'b0;
        bus.abort_i    = 1'b1;
        tick(acc);
        bus.abort_i = 1'b0;
        n_tests++;
        if (bus.out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_valid: out_valid=%b, required 0", bus.out_valid_o);
        end
        exp_q.delete();
        prev_stall = 0;
        set_abc();
        send_msg(-1);
    endtask

    task automatic test_async_reset();
        bit acc;
        int cnt;
        set_abc();
        push_expected();
        drive_word(0);
        cnt = 0;
        acc = 0;
        while (!acc && cnt < 50) begin
            tick(acc);
            cnt++;
        end
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        repeat (4) tick(acc);
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 32'h0 || bus.out_block_end_o !== 1'b0 ||
            bus.out_last_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b data=%h be=%b last=%b in_ready=%b, required 0 0 0 0 1",
                     bus.out_valid_o, bus.out_data_o, bus.out_block_end_o, bus.out_last_o, bus.in_ready_o);
        end
        exp_q.delete();
        prev_stall = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_abc();
        send_msg(-1);
    endtask

    task automatic test_back_to_back();
        rdy_mode = 1;
        for (int m = 0; m < 4; m++) begin
            set_random($urandom_range(1, 130));
            send_msg(-1);
        end
        rdy_mode = 0;
        bus.out_ready_i = 1'b1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 32'h0;
        bus.in_last_i   = 1'b0;
        bus.in_bytes_i  = 2'd0;
        bus.empty_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        test_reset();
        test_abc();
        test_empty();
        test_boundaries();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lw_sha_msg_padder.md
LW_SHA_MSG_PADDER -- requirements
Module: lw_sha_msg_padder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning message word width in bits; only 32 is supported.
REQ-002 SHALL have ports clk_i  in  1  clock, rising edge.
REQ-003 SHALL have ports areset_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid_i  in  1  input word valid; in_ready_o  out  1  input word accepted when both high.
REQ-005 SHALL have ports in_data_i  in  32  message word, big-endian: first byte in [31:24].
REQ-006 SHALL have ports in_last_i  in  1  final message word; in_bytes_i  in  2  valid bytes in final word, 0 meaning 4.
REQ-007 SHALL have ports empty_i  in  1  single-cycle request to pad a zero-length message.
REQ-008 SHALL have ports abort_i  in  1  synchronous abort.
REQ-009 SHALL have ports out_valid_o  out  1, out_ready_i  in  1, out_data_o  out  32  padded word stream to the hash core.
REQ-010 SHALL have ports out_block_end_o  out  1  word index 15 of a block; out_last_o  out  1  final word of final block.

Function
REQ-011 SHALL implement states DATA (reset state), PAD, ZERO, LEN_HI, LEN_LO.
REQ-012 Output register SHALL hold out_data_o/out_block_end_o/out_last_o stable while out_valid_o=1 and out_ready_i=0.
REQ-013 Output register SHALL load when empty (out_valid_o=0) or drained this cycle (out_ready_i=1); one-cycle latency from input accept to out_valid_o.
REQ-014 in_ready_o SHALL equal (state==DATA) and (out_valid_o==0 or out_ready_i==1), combinationally.
REQ-015 4-bit word index SHALL increment mod 16 on every loaded output word; out_block_end_o=1 when the loaded word has index 15.
REQ-016 64-bit bit length SHALL add 32 per accepted non-final word and 8*bytes for the final word; wraps mod 2^64.
REQ-017 DATA, in_last_i=0: word passed unchanged; stay DATA.
REQ-018 DATA, in_last_i=1, in_bytes_i=1..3: valid bytes kept, next byte=0x80, remaining bytes 0; go ZERO if next index!=14, else LEN_HI.
REQ-019 DATA, in_last_i=1, in_bytes_i=0: word passed unchanged; go PAD.
REQ-020 PAD SHALL emit 0x80000000; then ZERO or LEN_HI per REQ-018 index rule.
REQ-021 ZERO SHALL emit 0x00000000 words until next index is 14, crossing into a second block when pad landed at index 14 or 15; then LEN_HI.
REQ-022 LEN_HI SHALL emit length[63:32]; LEN_LO SHALL emit length[31:0] with out_last_o=1, then return DATA with index and length cleared.
REQ-023 empty_i in DATA with index 0 and length 0 SHALL act as PAD entry with length 0; ignored otherwise.
REQ-024 in_valid_i and empty_i together SHALL give in_valid_i priority; empty_i ignored.
REQ-025 abort_i SHALL, next edge, force DATA, clear index, length and out_valid_o; abort_i has priority over all other inputs.
REQ-026 Pending output word SHALL NOT be dropped or duplicated under backpressure.

Reset
REQ-027 areset_i=1 SHALL immediately force state DATA, index 0, length 0, out_valid_o=0, out_data_o=0, out_block_end_o=0, out_last_o=0, independent of clk_i.
REQ-028 Reset mid-message SHALL discard all partial state; first post-reset word is index 0 of a new message.

Verification
REQ-029 "abc": one word 0x61626300, last, bytes=3 -> 0x61626380, 13 zeros, 0x00000000, 0x00000018; out_last_o and out_block_end_o on word 16.
REQ-030 empty_i pulse -> 0x80000000, 14 zeros, 0x00000000 with out_last_o=1; 16 words total.
REQ-031 14 full words, last with bytes=0 -> data words 0-13, 0x80000000 at 14, 0 at 15, then block 2: 14 zeros, 0x00000000, 0x000001C0; 32 words, out_block_end_o at 16 and 32.
REQ-032 out_ready_i low 3 cycles mid-stream -> out_data_o and out_valid_o stable, in_ready_o=0, no loss or duplication.
REQ-033 abort_i after 5 words -> out_valid_o=0 next cycle; new "abc" produces REQ-029 output exactly.
REQ-034 areset_i asserted between clock edges during ZERO -> outputs 0 immediately; state DATA after release.
